// File: rtl/grant_sink_finish_gen_pkg.sv
// Purpose: shared Grant-channel field widths, grant-type codes and decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a. Reused by the arbiter lock logic and the grant sink.
package grant_sink_finish_gen_pkg;

   localparam int ADDR_BEAT_W         = 3;
   localparam int CLIENT_XACT_ID_W    = 2;
   localparam int MANAGER_XACT_ID_W   = 1;
   localparam int G_TYPE_W            = 4;
   localparam int DATA_W              = 64;
   localparam int MANAGER_ID_W        = 2;

   localparam int BEATS = 8;

   localparam logic [G_TYPE_W-1:0] G_TYPE_BUILTIN_MULTIBEAT = 4'h5;
   localparam logic [G_TYPE_W-1:0] G_TYPE_CACHED_MULTIBEAT  = 4'h0;
   localparam logic [G_TYPE_W-1:0] G_TYPE_VOLUNTARY_ACK     = 4'h0;

   // One grant beat as stored in the beat FIFO (75 bits).
   typedef struct packed {
      logic [ADDR_BEAT_W-1:0]       addr_beat;
      logic [CLIENT_XACT_ID_W-1:0]  client_xact_id;
      logic [MANAGER_XACT_ID_W-1:0] manager_xact_id;
      logic                         is_builtin_type;
      logic [G_TYPE_W-1:0]          g_type;
      logic [DATA_W-1:0]            data;
   } grant_t;

   // One Finish message as stored in the Finish FIFO (3 bits).
   typedef struct packed {
      logic [MANAGER_XACT_ID_W-1:0] manager_xact_id;
      logic [MANAGER_ID_W-1:0]      manager_id;
   } fin_t;

   function automatic logic is_multibeat(input logic is_builtin_type,
                                         input logic [G_TYPE_W-1:0] g_type);
      return is_builtin_type ? (g_type == G_TYPE_BUILTIN_MULTIBEAT)
                             : (g_type == G_TYPE_CACHED_MULTIBEAT);
   endfunction

   // Only the built-in voluntary ack completes without a Finish.
   function automatic logic needs_finish(input logic is_builtin_type,
                                         input logic [G_TYPE_W-1:0] g_type);
      return !(is_builtin_type && (g_type == G_TYPE_VOLUNTARY_ACK));
   endfunction

endpackage

// File: rtl/grant_sink_finish_gen_sync_queue.sv
// Purpose: generic synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH power of two).
// Latency: 1 cycle enqueue to deq_valid; no combinational bypass.
// Backpressure: enqueue ignored while full (full from current occupancy, not relieved by same-cycle dequeue).
// Ports: enq_valid/enq_data in, deq_valid/deq_data out, deq_ready in, full out.
module sync_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_valid,
   input  logic [WIDTH-1:0] enq_data,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_data,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_enq;
   logic             do_deq;

   assign full      = (count == CNT_W'(DEPTH));
   assign deq_valid = (count != '0);
   assign do_enq    = enq_valid && !full;
   assign do_deq    = deq_valid && deq_ready;
   // Head is always visible, even when empty.
   assign deq_data  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + 1'b1;
         if (do_deq) rd_ptr <= rd_ptr + 1'b1;
         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/grant_sink_finish_gen.sv
// Purpose: buffer arbitrated grant beats to the client, track multi-beat progress, emit one Finish per completed grant.
// Latency: 1 cycle in->out for beats and for Finish messages.
// Backpressure: io_in_ready drops when the beat FIFO is full, or on a Finish-bearing last beat while the Finish FIFO is full.
// Ports: io_in_* grant beat + io_in_chosen in, io_out_* buffered beats out,
//        io_finish_* Finish {manager_xact_id, manager_id} out, io_beat_error sticky.
module grant_sink_finish_gen
   import grant_sink_finish_gen_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int BEATS     = grant_sink_finish_gen_pkg::BEATS,
   parameter int FIN_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         io_in_ready,
   input  logic                         io_in_valid,
   input  logic [ADDR_BEAT_W-1:0]       io_in_bits_addr_beat,
   input  logic [CLIENT_XACT_ID_W-1:0]  io_in_bits_client_xact_id,
   input  logic [MANAGER_XACT_ID_W-1:0] io_in_bits_manager_xact_id,
   input  logic                         io_in_bits_is_builtin_type,
   input  logic [G_TYPE_W-1:0]          io_in_bits_g_type,
   input  logic [DATA_W-1:0]            io_in_bits_data,
   input  logic [MANAGER_ID_W-1:0]      io_in_chosen,
   input  logic                         io_out_ready,
   output logic                         io_out_valid,
   output logic [ADDR_BEAT_W-1:0]       io_out_bits_addr_beat,
   output logic [CLIENT_XACT_ID_W-1:0]  io_out_bits_client_xact_id,
   output logic [MANAGER_XACT_ID_W-1:0] io_out_bits_manager_xact_id,
   output logic                         io_out_bits_is_builtin_type,
   output logic [G_TYPE_W-1:0]          io_out_bits_g_type,
   output logic [DATA_W-1:0]            io_out_bits_data,
   input  logic                         io_finish_ready,
   output logic                         io_finish_valid,
   output logic [MANAGER_XACT_ID_W-1:0] io_finish_bits_manager_xact_id,
   output logic [MANAGER_ID_W-1:0]      io_finish_bits_manager_id,
   output logic                         io_beat_error
);

   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   grant_t          in_beat;
   grant_t          out_beat;
   fin_t            fin_in;
   fin_t            fin_out;
   logic [CNT_W-1:0] beat_cnt;
   logic            multi;
   logic            last_beat;
   logic            fin_now;
   logic            acc;
   logic            beat_full;
   logic            fin_full;

   assign in_beat = '{addr_beat:       io_in_bits_addr_beat,
                      client_xact_id:  io_in_bits_client_xact_id,
                      manager_xact_id: io_in_bits_manager_xact_id,
                      is_builtin_type: io_in_bits_is_builtin_type,
                      g_type:          io_in_bits_g_type,
                      data:            io_in_bits_data};

   // Decode the presented beat, valid or not; ready may depend on it.
   assign multi     = is_multibeat(io_in_bits_is_builtin_type, io_in_bits_g_type);
   assign last_beat = !multi || (beat_cnt == LAST_BEAT);
   assign fin_now   = last_beat && needs_finish(io_in_bits_is_builtin_type, io_in_bits_g_type);

   // A Finish-bearing last beat waits as a whole until the Finish queue has room.
   assign io_in_ready = !beat_full && (!fin_now || !fin_full);
   assign acc         = io_in_valid && io_in_ready;

   assign fin_in = '{manager_xact_id: io_in_bits_manager_xact_id,
                     manager_id:      io_in_chosen};

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt      <= '0;
         io_beat_error <= 1'b0;
      end else if (acc) begin
         if (multi) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            if (io_in_bits_addr_beat != ADDR_BEAT_W'(beat_cnt)) io_beat_error <= 1'b1;
         end else if (beat_cnt != '0) begin
            // Single-beat grant arriving in the middle of a multi-beat one.
            io_beat_error <= 1'b1;
         end
      end
   end

   sync_queue #(
      .WIDTH ($bits(grant_t)),
      .DEPTH (DEPTH)
   ) u_beat_q (
      .clk       (clk),
      .reset     (reset),
      .enq_valid (acc),
      .enq_data  (in_beat),
      .deq_valid (io_out_valid),
      .deq_ready (io_out_ready),
      .deq_data  (out_beat),
      .full      (beat_full)
   );

   sync_queue #(
      .WIDTH ($bits(fin_t)),
      .DEPTH (FIN_DEPTH)
   ) u_fin_q (
      .clk       (clk),
      .reset     (reset),
      .enq_valid (acc && fin_now),
      .enq_data  (fin_in),
      .deq_valid (io_finish_valid),
      .deq_ready (io_finish_ready),
      .deq_data  (fin_out),
      .full      (fin_full)
   );

   assign io_out_bits_addr_beat          = out_beat.addr_beat;
   assign io_out_bits_client_xact_id     = out_beat.client_xact_id;
   assign io_out_bits_manager_xact_id    = out_beat.manager_xact_id;
   assign io_out_bits_is_builtin_type    = out_beat.is_builtin_type;
   assign io_out_bits_g_type             = out_beat.g_type;
   assign io_out_bits_data               = out_beat.data;
   assign io_finish_bits_manager_xact_id = fin_out.manager_xact_id;
   assign io_finish_bits_manager_id      = fin_out.manager_id;

endmodule

// File: doc/grant_sink_finish_gen.md
Name: grant_sink_finish_gen

Overview:
- Sits directly downstream of the 4-way locking grant arbiter on the Grant channel.
- Takes the arbitrated grant stream plus the arbiter's chosen-index and buffers grant beats in a DEPTH-entry FIFO toward the client.
- Tracks beat progress of multi-beat grants.
- Emits one Finish message per completed grant that requires acknowledgement, tagged with the manager index, through a separate 2-entry Finish queue.

Parameters:
- DEPTH, 2, grant beat FIFO entries (power of two, >= 2).
- BEATS, 8, beats per multi-beat grant; beat counter width is log2(BEATS) = 3.
- FIN_DEPTH, 2, Finish queue entries (power of two).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- io_in_ready  out  1  grant beat accepted when high with io_in_valid
- io_in_valid  in  1  arbitrated grant beat valid
- io_in_bits_addr_beat  in  3  beat index
- io_in_bits_client_xact_id  in  2  client transaction id
- io_in_bits_manager_xact_id  in  1  manager transaction id
- io_in_bits_is_builtin_type  in  1  built-in grant type flag
- io_in_bits_g_type  in  4  grant type
- io_in_bits_data  in  64  beat data
- io_in_chosen  in  2  arbiter-chosen manager index, qualified by io_in_valid
- io_out_ready  in  1  client accepts beat
- io_out_valid  out  1  buffered beat valid
- io_out_bits_*  out  3/2/1/1/4/64  same fields as io_in_bits_*, FIFO order
- io_finish_ready  in  1  Finish channel accepts
- io_finish_valid  out  1  Finish pending
- io_finish_bits_manager_xact_id  out  1  from the grant's last beat
- io_finish_bits_manager_id  out  2  io_in_chosen captured at the last beat
- io_beat_error  out  1  sticky beat-sequence error

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset: clears both FIFOs (io_out_valid = 0, io_finish_valid = 0), beat counter = 0, io_beat_error = 0. FIFO data storage is not reset.
- Multi-beat grant:
  - is_builtin_type && g_type == 4'h5, or
  - !is_builtin_type && g_type == 4'h0.
  - All other grants are single-beat.
- Finish required: every grant except is_builtin_type && g_type == 4'h0 (voluntary ack).
- Accept: acc = io_in_valid && io_in_ready.
- Last beat:
  - Single-beat grant: every accepted beat is a last beat.
  - Multi-beat grant: the accepted beat with counter == BEATS-1.
- fin_now = acc-candidate beat is a last beat && Finish required.
- io_in_ready = !beat_fifo_full && (!fin_now || !fin_fifo_full).
  - Combinational from FIFO state and io_in_bits; independent of io_in_valid except through fin_now's field decode.
  - Stalls the whole last beat when the Finish queue is full; no partial accept.
- Beat FIFO:
  - Write on acc; read on io_out_valid && io_out_ready.
  - Minimum latency 1 cycle, in to out; no combinational bypass.
  - Simultaneous read and write when full: the write is not accepted (ready is based on the current full flag). When empty, a write is seen next cycle.
  - Occupancy counter width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Beat counter:
  - Increments on acc of a multi-beat beat and wraps BEATS-1 -> 0.
  - Unchanged on single-beat grants.
- io_beat_error: set on acc of a multi-beat beat whose addr_beat != counter, or of a single-beat grant while counter != 0. Cleared only by reset.
- Finish queue:
  - Write on acc && fin_now, with {manager_xact_id, io_in_chosen}.
  - Read on io_finish_valid && io_finish_ready.
  - Minimum latency 1 cycle; one write per cycle at most.
- Reset asserted mid-grant: counter returns to 0; all buffered beats and Finishes are dropped. The next accepted beat is treated as a grant start.
- Outputs are undefined-safe: io_out_bits hold FIFO head contents even when io_out_valid = 0.

Decomposition:
- Shared package:
  - Grant field widths (3/2/1/1/4/64).
  - G_TYPE_BUILTIN_MULTIBEAT = 4'h5, G_TYPE_CACHED_MULTIBEAT = 4'h0, G_TYPE_VOLUNTARY_ACK = 4'h0.
  - BEATS, and the multibeat/needs-finish decode functions, reused by the arbiter's lock logic.
- Sub-module: one generic sync FIFO, sync_queue (WIDTH, DEPTH), instantiated twice: beat FIFO WIDTH = 75, Finish FIFO WIDTH = 3.

Test Plan:
- Single-beat putAck: is_builtin = 1, g_type = 2, xact = 1, chosen = 2 -> io_out beat appears the next cycle; Finish {xact = 1, id = 2} valid the next cycle; counter stays 0.
- 8-beat getDataBlock: is_builtin = 1, g_type = 5, addr_beat 0..7, data = beat*0x11, io_out_ready = 1 -> 8 beats out in order; exactly one Finish, after beat 7; io_beat_error = 0.
- Voluntary ack: is_builtin = 1, g_type = 0 -> beat forwarded; no Finish; io_finish_valid stays 0.
- Finish backpressure: io_finish_ready = 0 with 2 single-beat putAcks queued; a 3rd putAck is presented -> io_in_ready = 0 and no beat is written. When io_finish_ready = 1 for 1 cycle, io_in_ready returns to 1 the next cycle.
- Beat FIFO full: io_out_ready = 0 with a multi-beat grant -> accepts DEPTH = 2 beats, then io_in_ready = 0. Releasing io_out_ready drains beats in order and the counter continues at 2.
- Sequence error and reset: multi-beat beats 0, 1, 3 -> io_beat_error = 1 after the third accept. Reset mid-grant -> io_beat_error = 0, both valids = 0, and the next beat 0 is accepted without error.
